obstacle_manager: RTL and testbench

//  Owns and sequences the obstacle table consumed by the track renderer: spawns obstacles
//  off-screen right in pseudo-random lanes, scrolls them left once per frame, retires them
//  at the left edge, and flags a player collision. All table writes occur during vertical

---
 rtl/obstacle_manager_pkg.sv | 27 ++
 rtl/obstacle_manager_if.sv | 24 ++
 rtl/obstacle_manager_lfsr16.sv | 27 ++
 rtl/obstacle_manager.sv | 134 +++++++++++++
 tb/tb_obstacle_manager.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obstacle_manager_pkg.sv
// Obstacle table types and playfield geometry shared by
// the obstacle manager, its interface and the renderer.
package obstacle_manager_pkg;
   localparam int NUM_OBSTACLES  = 10;
   localparam int SCREEN_WIDTH   = 1024;
   localparam int OBSTACLE_WIDTH = 64;
   localparam int LANE_HEIGHT    = 80;
   localparam int PLAYER_X       = 64;
   localparam int PLAYER_WIDTH   = 32;

   localparam logic [10:0] SPAWN_POS =
      11'(SCREEN_WIDTH + OBSTACLE_WIDTH);

   typedef struct packed {
      logic        active;
      logic [1:0]  lane;
      logic [10:0] position;
   } obstacle_t;

   function automatic logic in_player_zone(
      input logic [10:0] pos
   );
      return (pos > 11'(PLAYER_X)) &&
             ((pos - 11'(OBSTACLE_WIDTH)) <
              11'(PLAYER_X + PLAYER_WIDTH));
   endfunction
endpackage

// File: rtl/obstacle_manager_if.sv
// Game-side signals of the obstacle manager: frame timing,
// player state in, obstacle table and score out.
interface obstacle_manager_if;
   import obstacle_manager_pkg::*;

   logic vsync;
   logic enable;
   logic [3:0] speed;
   logic [1:0] lane;
   logic jump;
   obstacle_t [NUM_OBSTACLES-1:0] obstacles;
   logic collision;
   logic [15:0] score;

   modport master (
      output vsync, enable, speed, lane, jump,
      input  obstacles, collision, score
   );

   modport slave (
      input  vsync, enable, speed, lane, jump,
      output obstacles, collision, score
   );
endinterface

// File: rtl/obstacle_manager_lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400) advancing one step
// per asserted step_i; drives spawn lane and spawn delay.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        step_i,
   output logic [15:0] state_o
);
   logic [15:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (step_i) begin
         state_d = {1'b0, state_q[15:1]} ^
                   (state_q[0] ? 16'hB400 : 16'h0000);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= SEED;
      else       state_q <= state_d;
   end

   assign state_o = state_q;
endmodule

// File: rtl/obstacle_manager.sv
// Obstacle table sequencer: one sweep per frame tick that
// scrolls/retires each slot, then optionally spawns one.
module obstacle_manager
   import obstacle_manager_pkg::*;
#(
   parameter int          SPAWN_MIN_FRAMES = 20,
   parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
   input logic system_clock_in,
   input logic reset_in,
   obstacle_manager_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_e;

   localparam logic [3:0] LAST = 4'(NUM_OBSTACLES - 1);

   state_e state_q, state_d;
   logic [3:0] idx_q, idx_d;
   obstacle_t [NUM_OBSTACLES-1:0] tbl_q, tbl_d;
   logic coll_q, coll_d;
   logic [15:0] score_q, score_d;
   logic [5:0] timer_q, timer_d;
   logic vsync_q;

   logic tick, go;
   logic [15:0] lfsr;
   logic [1:0] spawn_lane;
   logic [10:0] spd, newpos;
   obstacle_t cur;
   logic free_found;
   logic [3:0] free_idx;
   logic unused_lfsr;

   assign tick = vsync_q & ~bus.vsync;
   assign go = (state_q == IDLE) & tick &
               bus.enable & ~coll_q;
   assign spd = {7'b0, bus.speed};
   assign spawn_lane = (lfsr[1:0] == 2'd3) ? 2'd1
                                           : lfsr[1:0];
   assign unused_lfsr = ^{lfsr[15:8], lfsr[3:2]};

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk_i  (system_clock_in),
      .rst_i  (reset_in),
      .step_i (go),
      .state_o(lfsr)
   );

   always_comb begin
      free_found = 1'b0;
      free_idx = '0;
      for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
         if (!tbl_q[i].active) begin
            free_found = 1'b1;
            free_idx = 4'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      tbl_d = tbl_q;
      coll_d = coll_q;
      score_d = score_q;
      timer_d = timer_q;
      cur = tbl_q[idx_q];
      newpos = cur.position - spd;
      unique case (state_q)
         IDLE: begin
            if (go) begin
               state_d = MOVE;
               idx_d = '0;
            end
         end
         MOVE: begin
            if (cur.active) begin
               if (cur.position <= spd) begin
                  tbl_d[idx_q].active = 1'b0;
                  tbl_d[idx_q].position = '0;
                  if (score_q != 16'hFFFF)
                     score_d = score_q + 16'd1;
               end else begin
                  tbl_d[idx_q].position = newpos;
                  if (cur.lane == bus.lane && !bus.jump &&
                      in_player_zone(newpos))
                     coll_d = 1'b1;
               end
            end
            if (idx_q == LAST) state_d = SPAWN;
            else               idx_d = idx_q + 4'd1;
         end
         SPAWN: begin
            timer_d = timer_q - 6'd1;
            // Reload even when full so a full table drops the spawn
            if (timer_q == 6'd1) begin
               timer_d = 6'(SPAWN_MIN_FRAMES) +
                         {2'b00, lfsr[7:4]};
               if (free_found) begin
                  tbl_d[free_idx].active = 1'b1;
                  tbl_d[free_idx].lane = spawn_lane;
                  tbl_d[free_idx].position = SPAWN_POS;
               end
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge system_clock_in) begin
      if (reset_in) begin
         state_q <= IDLE;
         idx_q <= '0;
         tbl_q <= '0;
         coll_q <= 1'b0;
         score_q <= '0;
         timer_q <= 6'(SPAWN_MIN_FRAMES);
         vsync_q <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         tbl_q <= tbl_d;
         coll_q <= coll_d;
         score_q <= score_d;
         timer_q <= timer_d;
         vsync_q <= bus.vsync;
      end
   end

   assign bus.obstacles = tbl_q;
   assign bus.collision = coll_q;
   assign bus.score = score_q;
endmodule

// File: tb/tb_obstacle_manager.sv
// Randomized frame-level bench for obstacle_manager against
// a per-frame behavioural model of the obstacle table.
module tb_obstacle_manager;
   import obstacle_manager_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;

   obstacle_manager_if bus();

   obstacle_manager dut (
      .system_clock_in(clk),
      .reset_in       (rst),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   int m_act [NUM_OBSTACLES];
   int m_lane[NUM_OBSTACLES];
   int m_pos [NUM_OBSTACLES];
   bit m_coll;
   int m_score;
   int m_timer;
   logic [15:0] m_lfsr;
   obstacle_t [NUM_OBSTACLES-1:0] exp;

   function automatic void model_reset();
      for (int i = 0; i < NUM_OBSTACLES; i++) begin
         m_act[i] = 0; m_lane[i] = 0; m_pos[i] = 0;
      end
      m_coll = 0; m_score = 0; m_timer = 20;
      m_lfsr = 16'hACE1;
   endfunction

   function automatic void model_frame(
      input int spd, input int pl,
      input bit jmp, input bit en
   );
      int slot;
      if (!en || m_coll) return;
      m_lfsr = {1'b0, m_lfsr[15:1]} ^
               (m_lfsr[0] ? 16'hB400 : 16'h0000);
      for (int i = 0; i < NUM_OBSTACLES; i++) begin
         if (m_act[i] == 0) continue;
         if (m_pos[i] <= spd) begin
            m_act[i] = 0; m_pos[i] = 0;
            if (m_score < 65535) m_score++;
         end else begin
            m_pos[i] -= spd;
            if (m_lane[i] == pl && !jmp &&
                m_pos[i] > 64 && m_pos[i] < 160)
               m_coll = 1;
         end
      end
      m_timer--;
      if (m_timer == 0) begin
         slot = -1;
         for (int i = NUM_OBSTACLES - 1; i >= 0; i--)
            if (m_act[i] == 0) slot = i;
         if (slot >= 0) begin
            m_act[slot] = 1;
            m_lane[slot] = (m_lfsr[1:0] == 2'd3) ? 1
                                                 : int'(m_lfsr[1:0]);
            m_pos[slot] = 1088;
         end
         m_timer = 20 + int'(m_lfsr[7:4]);
      end
   endfunction

   function automatic void pack_model();
      for (int i = 0; i < NUM_OBSTACLES; i++) begin
         exp[i].active = m_act[i][0];
         exp[i].lane = 2'(m_lane[i]);
         exp[i].position = 11'(m_pos[i]);
      end
   endfunction

   task automatic run_frame(
      input int spd, input int pl,
      input bit jmp, input bit en
   );
      bus.speed = 4'(spd); bus.lane = 2'(pl);
      bus.jump = jmp; bus.enable = en;
      @(negedge clk) bus.vsync = 1'b0;
      repeat (2) @(negedge clk);
      bus.vsync = 1'b1;
      repeat (14) @(negedge clk);
      model_frame(spd, pl, jmp, en);
      pack_model();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      tests++;
      if (bus.obstacles !== '0) begin
         fails++;
         $display("FAIL reset_table got %h want 0", bus.obstacles);
      end
      tests++;
      if (bus.collision !== 1'b0) begin
         fails++;
         $display("FAIL reset_coll got %b want 0", bus.collision);
      end
      tests++;
      if (bus.score !== 16'd0) begin
         fails++;
         $display("FAIL reset_score got %0d want 0", bus.score);
      end
   endtask

   task automatic test_first_spawn();
      for (int f = 0; f < 25; f++) begin
         run_frame(4, 0, 1'b1, 1'b1);
         tests++;
         if (bus.obstacles !== exp) begin
            fails++;
            $display("FAIL first_spawn f%0d got %h want %h",
                     f, bus.obstacles, exp);
         end
         if (f == 19) begin
            tests++;
            if (bus.obstacles[0].active !== 1'b1 ||
                bus.obstacles[0].position !== 11'd1088 ||
                bus.obstacles[0].lane > 2'd2) begin
               fails++;
               $display("FAIL spawn_slot0 got %h want active@1088",
                        bus.obstacles[0]);
            end
         end
      end
   endtask

   task automatic test_random_run(input int frames, input int smax);
      for (int f = 0; f < frames; f++) begin
         run_frame(int'($urandom_range(smax, 0)),
                   int'($urandom_range(2, 0)), 1'b1, 1'b1);
         tests++;
         if (bus.obstacles !== exp ||
             bus.score !== 16'(m_score) ||
             bus.collision !== m_coll) begin
            fails++;
            $display("FAIL random_run f%0d got %h/%0d/%b want %h/%0d/%b",
                     f, bus.obstacles, bus.score, bus.collision,
                     exp, m_score, m_coll);
         end
      end
   endtask

   task automatic test_table_full();
      int full_frames = 0;
      for (int f = 0; f < 400; f++) begin
         run_frame(0, int'($urandom_range(2, 0)), 1'b1, 1'b1);
         if (exp[0].active && exp[9].active) full_frames++;
         tests++;
         if (bus.obstacles !== exp) begin
            fails++;
            $display("FAIL table_full f%0d got %h want %h",
                     f, bus.obstacles, exp);
         end
      end
      tests++;
      if (full_frames < 40) begin
         fails++;
         $display("FAIL full_reached got %0d frames want >=40",
                  full_frames);
      end
      test_random_run(150, 15);
   endtask

   task automatic test_dropped_tick();
      bus.speed = 4'd7; bus.lane = 2'd2;
      bus.jump = 1'b1; bus.enable = 1'b1;
      @(negedge clk) bus.vsync = 1'b0;
      @(negedge clk) bus.vsync = 1'b1;
      repeat (3) @(negedge clk);
      bus.vsync = 1'b0;
      @(negedge clk) bus.vsync = 1'b1;
      repeat (16) @(negedge clk);
      model_frame(7, 2, 1'b1, 1'b1);
      pack_model();
      tests++;
      if (bus.obstacles !== exp || bus.score !== 16'(m_score)) begin
         fails++;
         $display("FAIL dropped_tick got %h/%0d want %h/%0d",
                  bus.obstacles, bus.score, exp, m_score);
      end
   endtask

   task automatic test_pause();
      for (int f = 0; f < 10; f++) begin
         run_frame(int'($urandom_range(15, 1)), 0, 1'b0, 1'b0);
         tests++;
         if (bus.obstacles !== exp || bus.score !== 16'(m_score)) begin
            fails++;
            $display("FAIL pause f%0d got %h want %h",
                     f, bus.obstacles, exp);
         end
      end
   endtask

   task automatic test_collision();
      int pl, best;
      for (int f = 0; f < 500 && !m_coll; f++) begin
         pl = 0; best = 4096;
         for (int i = 0; i < NUM_OBSTACLES; i++)
            if (m_act[i] != 0 && m_pos[i] > 64 && m_pos[i] < best) begin
               best = m_pos[i]; pl = m_lane[i];
            end
         run_frame(4, pl, 1'b0, 1'b1);
         tests++;
         if (bus.obstacles !== exp ||
             bus.collision !== m_coll ||
             bus.score !== 16'(m_score)) begin
            fails++;
            $display("FAIL collision f%0d got %h/%b want %h/%b",
                     f, bus.obstacles, bus.collision, exp, m_coll);
         end
      end
      tests++;
      if (bus.collision !== 1'b1) begin
         fails++;
         $display("FAIL collision_set got %b want 1", bus.collision);
      end
      for (int f = 0; f < 5; f++) begin
         run_frame(int'($urandom_range(15, 1)),
                   int'($urandom_range(2, 0)), 1'b0, 1'b1);
         tests++;
         if (bus.obstacles !== exp || bus.collision !== 1'b1) begin
            fails++;
            $display("FAIL frozen f%0d got %h/%b want %h/1",
                     f, bus.obstacles, bus.collision, exp);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      bus.speed = 4'd3; bus.enable = 1'b1; bus.jump = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int f = 0; f < 22; f++) run_frame(3, 1, 1'b1, 1'b1);
      @(negedge clk) bus.vsync = 1'b0;
      @(negedge clk) bus.vsync = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      tests++;
      if (bus.obstacles !== '0 || bus.collision !== 1'b0 ||
          bus.score !== 16'd0) begin
         fails++;
         $display("FAIL mid_sweep_reset got %h/%b/%0d want 0/0/0",
                  bus.obstacles, bus.collision, bus.score);
      end
      rst = 1'b0;
      test_pause();
      test_first_spawn();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.vsync = 1'b1; bus.enable = 1'b0; bus.speed = '0;
      bus.lane = '0; bus.jump = 1'b0;
      test_reset();
      test_first_spawn();
      test_random_run(300, 15);
      test_table_full();
      test_dropped_tick();
      test_pause();
      test_collision();
      test_reset_mid_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
